// File: rtl/dmem_sb_pkg.sv
// dmem_sb_pkg
//   Shared definitions for the data-memory store buffer:
//     - RISC-V funct3 encodings for stores and loads
//     - entry width encoding (0=byte, 1=half, 2=word) and width_bytes()
//     - sb_entry_t, one buffered store
//     - load_width() / load_extend(), the latter used by both the
//       memory pass-through path and the forwarding path
//   Optional forwarding in the top level is enabled by DMEM_SB_FWD_EN.
package dmem_sb_pkg;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;

  // Only the low 10 address bits matter: the memory aliases every 1 KB.
  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
    logic [1:0]  width;
  } sb_entry_t;

  function automatic logic [2:0] width_bytes(input logic [1:0] w);
    case (w)
      W_BYTE:  return 3'd1;
      W_HALF:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic store_f3_ok(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

  // Unknown load encodings are treated as word-sized so the hazard
  // check stays conservative.
  function automatic logic [1:0] load_width(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return W_BYTE;
      F3_LH, F3_LHU: return W_HALF;
      F3_LW:         return W_WORD;
      default:       return W_WORD;
    endcase
  endfunction

  // raw holds the addressed byte in bits [7:0].
  function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                              input logic [31:0] raw);
    case (f3)
      F3_LB:   return {{24{raw[7]}}, raw[7:0]};
      F3_LH:   return {{16{raw[15]}}, raw[15:0]};
      F3_LBU:  return {24'h0, raw[7:0]};
      F3_LHU:  return {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/sb_overlap_chk.sv
// sb_overlap_chk
//   Byte-footprint overlap test between two accesses in the 1 KB aliased
//   address space (10-bit wrap arithmetic).
//   Ports:
//     a_addr/a_width  first access (address, width code)
//     b_addr/b_width  second access
//     overlap         1 when any byte is shared
module sb_overlap_chk
  import dmem_sb_pkg::*;
(
  input  logic [9:0] a_addr,
  input  logic [1:0] a_width,
  input  logic [9:0] b_addr,
  input  logic [1:0] b_width,
  output logic       overlap
);

  logic [9:0] dist_ab;
  logic [9:0] dist_ba;

  // Two contiguous cyclic byte ranges intersect exactly when the start of
  // one falls inside the other; modular distances handle the wrap at 0x3FF.
  assign dist_ab = b_addr - a_addr;
  assign dist_ba = a_addr - b_addr;
  assign overlap = (dist_ab < {7'd0, width_bytes(a_width)}) ||
                   (dist_ba < {7'd0, width_bytes(b_width)});

endmodule

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer
//   FIFO store buffer between MEM-stage issue and the 1 KB data memory.
//   Stores queue here and drain one per cycle to the synchronous write
//   port; loads use the combinational read port with priority over draining,
//   and stall while they touch any buffered byte. A starvation counter
//   forces a drain after STARVE_LIMIT consecutive blocked cycles.
//   Optional macro DMEM_SB_FWD_EN: forward from the youngest overlapping
//   entry when it starts at the load address and is at least as wide.
//   Ports:
//     clk, rst                          clock, async active-high reset
//     st_valid/st_ready, st_funct3,
//     st_addr, st_data                  store request channel
//     ld_valid, ld_funct3, ld_addr,
//     ld_data, ld_stall                 combinational load channel
//     dm_mem_read, dm_mem_write,
//     dm_funct3, dm_addr,
//     dm_write_data, dm_read_data       data memory port
//     sb_empty, sb_count                occupancy status
//   Handshake: a store transfers on any rising edge with st_valid && st_ready;
//   st_ready depends only on registered occupancy. Stores with an unknown
//   funct3 still complete the handshake but are discarded.
module dmem_store_buffer
  import dmem_sb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [2:0]               st_funct3,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic                     ld_valid,
  input  logic [2:0]               ld_funct3,
  input  logic [31:0]              ld_addr,
  output logic [31:0]              ld_data,
  output logic                     ld_stall,
  output logic                     dm_mem_read,
  output logic                     dm_mem_write,
  output logic [2:0]               dm_funct3,
  output logic [31:0]              dm_addr,
  output logic [31:0]              dm_write_data,
  input  logic [31:0]              dm_read_data,
  output logic                     sb_empty,
  output logic [$clog2(DEPTH):0]   sb_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  sb_entry_t     entries [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;

  logic [DEPTH-1:0] entry_valid;
  logic [DEPTH-1:0] entry_ovl;
  logic [1:0]       ld_width;
  logic             buf_empty;
  logic             push;
  logic             ld_act;
  logic             hazard;
  logic             force_drain;
  logic             fwd_ok;
  logic             load_ok;
  logic             drain;
  sb_entry_t        head_entry;

  logic unused_st_addr_hi;
  assign unused_st_addr_hi = ^st_addr[31:10];

  assign buf_empty  = (count == '0);
  assign st_ready   = (count != CW'(DEPTH));
  assign sb_empty   = buf_empty;
  assign sb_count   = count;
  assign push       = st_valid && st_ready && store_f3_ok(st_funct3);
  assign head_entry = entries[head];

  // Loads are ignored while reset is held so every output sits at zero.
  assign ld_act   = ld_valid && !rst;
  assign ld_width = load_width(ld_funct3);

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] age;
    assign age            = PW'(i) - head;
    assign entry_valid[i] = ({1'b0, age} < count);

    sb_overlap_chk u_ovl (
      .a_addr  (entries[i].addr),
      .a_width (entries[i].width),
      .b_addr  (ld_addr[9:0]),
      .b_width (ld_width),
      .overlap (entry_ovl[i])
    );
  end

  assign hazard      = ld_act && |(entry_valid & entry_ovl);
  assign force_drain = !buf_empty && (starve_cnt == SW'(STARVE_LIMIT));

`ifdef DMEM_SB_FWD_EN
  logic [PW-1:0] fwd_idx;
  logic          fwd_hit;
  sb_entry_t     fwd_entry;

  // Walk oldest to youngest so the last overlapping entry wins.
  always_comb begin
    fwd_idx   = '0;
    fwd_hit   = 1'b0;
    fwd_entry = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head + PW'(k);
      if ((CW'(k) < count) && entry_ovl[fwd_idx]) begin
        fwd_hit   = 1'b1;
        fwd_entry = entries[fwd_idx];
      end
    end
  end

  // Same start address plus width >= load width means the load lies
  // entirely inside the entry, starting at its data bit 0.
  assign fwd_ok = hazard && fwd_hit &&
                  (fwd_entry.addr == ld_addr[9:0]) &&
                  (fwd_entry.width >= ld_width);
`else
  assign fwd_ok = 1'b0;
`endif

  // A forced drain takes the port and stalls any load that cycle.
  assign load_ok      = ld_act && !force_drain && (!hazard || fwd_ok);
  assign drain        = !buf_empty && !load_ok;
  assign ld_stall     = ld_act && !load_ok;
  assign dm_mem_read  = ld_act && !force_drain && !hazard;
  assign dm_mem_write = drain;

`ifdef DMEM_SB_FWD_EN
  assign ld_data = dm_mem_read        ? load_extend(ld_funct3, dm_read_data) :
                   (load_ok && fwd_ok) ? load_extend(ld_funct3, fwd_entry.data) :
                   32'h0;
`else
  assign ld_data = dm_mem_read ? load_extend(ld_funct3, dm_read_data) : 32'h0;
`endif

  always_comb begin
    dm_funct3     = 3'b000;
    dm_addr       = 32'h0;
    dm_write_data = 32'h0;
    if (drain) begin
      dm_funct3     = {1'b0, head_entry.width};
      dm_addr       = {22'h0, head_entry.addr};
      dm_write_data = head_entry.data;
    end else if (dm_mem_read) begin
      dm_funct3 = ld_funct3;
      dm_addr   = ld_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (drain) head <= head + PW'(1);
      case ({push, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      // Never passes STARVE_LIMIT: reaching it forces a drain, which clears it.
      if (buf_empty || drain) starve_cnt <= '0;
      else                    starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Entry storage needs no reset: validity comes from head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[tail] <= '{addr: st_addr[9:0], data: st_data, width: st_funct3[1:0]};
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer
//   Directed bench for dmem_store_buffer with a byte-array model of the
//   1 KB data memory (cleared by rst, little-endian, 10-bit wrap).
//   Expectations that differ with DMEM_SB_FWD_EN are selected by the macro.
module tb_dmem_store_buffer;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        ld_valid;
  logic [2:0]  ld_funct3;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_stall;
  logic        dm_mem_read;
  logic        dm_mem_write;
  logic [2:0]  dm_funct3;
  logic [31:0] dm_addr;
  logic [31:0] dm_write_data;
  logic [31:0] dm_read_data;
  logic        sb_empty;
  logic [2:0]  sb_count;

  int total = 0;
  int bad   = 0;

  dmem_store_buffer #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .st_valid      (st_valid),
    .st_ready      (st_ready),
    .st_funct3     (st_funct3),
    .st_addr       (st_addr),
    .st_data       (st_data),
    .ld_valid      (ld_valid),
    .ld_funct3     (ld_funct3),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .ld_stall      (ld_stall),
    .dm_mem_read   (dm_mem_read),
    .dm_mem_write  (dm_mem_write),
    .dm_funct3     (dm_funct3),
    .dm_addr       (dm_addr),
    .dm_write_data (dm_write_data),
    .dm_read_data  (dm_read_data),
    .sb_empty      (sb_empty),
    .sb_count      (sb_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [7:0] mem [1024];
  logic [9:0] ma0, ma1, ma2, ma3;
  assign ma0 = dm_addr[9:0];
  assign ma1 = ma0 + 10'd1;
  assign ma2 = ma0 + 10'd2;
  assign ma3 = ma0 + 10'd3;
  assign dm_read_data = dm_mem_read ? {mem[ma3], mem[ma2], mem[ma1], mem[ma0]} : 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else if (dm_mem_write) begin
      mem[ma0] <= dm_write_data[7:0];
      if (dm_funct3[1:0] != 2'd0) mem[ma1] <= dm_write_data[15:8];
      if (dm_funct3[1:0] == 2'd2) begin
        mem[ma2] <= dm_write_data[23:16];
        mem[ma3] <= dm_write_data[31:24];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1; st_funct3 = f3; st_addr = a; st_data = d;
    #1;
  endtask

  task automatic no_store();
    st_valid = 1'b0; st_funct3 = 3'b000; st_addr = 32'h0; st_data = 32'h0;
    #1;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a);
    ld_valid = 1'b1; ld_funct3 = f3; ld_addr = a;
    #1;
  endtask

  task automatic no_load();
    ld_valid = 1'b0; ld_funct3 = 3'b000; ld_addr = 32'h0;
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 20 && !sb_empty; i++) tick();
    chk(tag, {31'h0, sb_empty}, 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    st_valid = 1'b0; st_funct3 = 3'b000; st_addr = 32'h0; st_data = 32'h0;
    ld_valid = 1'b1; ld_funct3 = 3'b010; ld_addr = 32'h100;
    #2;
    chk("rst_count",    {29'h0, sb_count}, 32'h0);
    chk("rst_empty",    {31'h0, sb_empty}, 32'h1);
    chk("rst_ready",    {31'h0, st_ready}, 32'h1);
    chk("rst_wr",       {31'h0, dm_mem_write}, 32'h0);
    chk("rst_rd",       {31'h0, dm_mem_read}, 32'h0);
    chk("rst_addr",     dm_addr, 32'h0);
    chk("rst_ld_data",  ld_data, 32'h0);
    chk("rst_ld_stall", {31'h0, ld_stall}, 32'h0);

    tick();
    rst = 1'b0;
    no_load();

    // T1: SW then drain, then load back
    do_store(3'b010, 32'h100, 32'hDEADBEEF);
    chk("t1_ready", {31'h0, st_ready}, 32'h1);
    chk("t1_nowr_empty", {31'h0, dm_mem_write}, 32'h0);
    tick();
    no_store();
    chk("t1_count", {29'h0, sb_count}, 32'h1);
    chk("t1_wr", {31'h0, dm_mem_write}, 32'h1);
    chk("t1_waddr", dm_addr, 32'h100);
    chk("t1_wdata", dm_write_data, 32'hDEADBEEF);
    chk("t1_wf3", {29'h0, dm_funct3}, 32'h2);
    tick();
    chk("t1_empty", {31'h0, sb_empty}, 32'h1);
    do_load(3'b010, 32'h100);
    chk("t1_ld_data", ld_data, 32'hDEADBEEF);
    chk("t1_ld_stall", {31'h0, ld_stall}, 32'h0);
    chk("t1_rd", {31'h0, dm_mem_read}, 32'h1);

    // T2: fill under a non-overlapping load, then starvation force
    do_load(3'b010, 32'h300);
    do_store(3'b010, 32'h000, 32'hA0A00001); tick();
    do_store(3'b010, 32'h004, 32'hB0B00002); tick();
    do_store(3'b010, 32'h008, 32'hC0C00003); tick();
    do_store(3'b010, 32'h00C, 32'hD0D00004); tick();
    do_store(3'b010, 32'h010, 32'h99999999);           // cycle 4, full
    chk("t2_full_ready", {31'h0, st_ready}, 32'h0);
    chk("t2_full_count", {29'h0, sb_count}, 32'h4);
    chk("t2_c4_nowr", {31'h0, dm_mem_write}, 32'h0);
    chk("t2_c4_ld", ld_data, 32'h0);
    tick();
    no_store();
    chk("t2_push_full_rejected", {29'h0, sb_count}, 32'h4);
    tick(); tick(); tick();                            // cycle 8
    chk("t2_c8_nowr", {31'h0, dm_mem_write}, 32'h0);
    chk("t2_c8_stall", {31'h0, ld_stall}, 32'h0);
    tick();                                            // cycle 9: forced
    chk("t2_force_wr", {31'h0, dm_mem_write}, 32'h1);
    chk("t2_force_stall", {31'h0, ld_stall}, 32'h1);
    chk("t2_force_rd", {31'h0, dm_mem_read}, 32'h0);
    chk("t2_force_addr", dm_addr, 32'h0);
    chk("t2_force_data", dm_write_data, 32'hA0A00001);
    tick();                                            // counter cleared
    chk("t2_after_nowr", {31'h0, dm_mem_write}, 32'h0);
    chk("t2_after_stall", {31'h0, ld_stall}, 32'h0);
    chk("t2_after_count", {29'h0, sb_count}, 32'h3);
    no_load();
    wait_empty("t2_drain_empty");
    do_load(3'b010, 32'h008);
    chk("t2_lw_008", ld_data, 32'hC0C00003);
    do_load(3'b001, 32'h00E);
    chk("t2_lh_00e", ld_data, 32'hFFFFD0D0);
    do_load(3'b100, 32'h00F);
    chk("t2_lbu_00f", ld_data, 32'h000000D0);
    no_load();

    // T3: SB 0x203 then LH 0x202 (partial cover, stalls in both builds)
    do_store(3'b000, 32'h202, 32'h0000005A); tick();
    do_store(3'b000, 32'h203, 32'hFFFFFF80); tick();
    no_store();
    do_load(3'b001, 32'h202);
    chk("t3_count", {29'h0, sb_count}, 32'h1);
    chk("t3_stall", {31'h0, ld_stall}, 32'h1);
    chk("t3_rd", {31'h0, dm_mem_read}, 32'h0);
    chk("t3_wr", {31'h0, dm_mem_write}, 32'h1);
    chk("t3_waddr", dm_addr, 32'h203);
    chk("t3_wf3", {29'h0, dm_funct3}, 32'h0);
    tick();
    chk("t3_served_stall", {31'h0, ld_stall}, 32'h0);
    chk("t3_served_data", ld_data, 32'hFFFF805A);
    no_load();

    // T4: two SWs to 0x40 then LHU 0x40
    do_load(3'b010, 32'h300);
    do_store(3'b010, 32'h040, 32'h12348765); tick();
    do_store(3'b010, 32'h040, 32'hCAFEF00D); tick();
    no_store();
    do_load(3'b101, 32'h040);
    chk("t4_count", {29'h0, sb_count}, 32'h2);
    chk("t4_rd", {31'h0, dm_mem_read}, 32'h0);
`ifdef DMEM_SB_FWD_EN
    chk("t4_fwd_stall", {31'h0, ld_stall}, 32'h0);
    chk("t4_fwd_data", ld_data, 32'h0000F00D);
    chk("t4_fwd_nowr", {31'h0, dm_mem_write}, 32'h0);
`else
    chk("t4_stall0", {31'h0, ld_stall}, 32'h1);
    chk("t4_wr0", {31'h0, dm_mem_write}, 32'h1);
    chk("t4_wdata0", dm_write_data, 32'h12348765);
    tick();
    chk("t4_stall1", {31'h0, ld_stall}, 32'h1);
    chk("t4_wdata1", dm_write_data, 32'hCAFEF00D);
    tick();
    chk("t4_served_stall", {31'h0, ld_stall}, 32'h0);
    chk("t4_served_data", ld_data, 32'h0000F00D);
    chk("t4_served_rd", {31'h0, dm_mem_read}, 32'h1);
`endif
    no_load();
    wait_empty("t4_drain_empty");

    // T5: wrap-around SH 0x3FF then LB 0x000
    do_store(3'b001, 32'h3FF, 32'h0000AABB); tick();
    no_store();
    do_load(3'b000, 32'h000);
    chk("t5_stall", {31'h0, ld_stall}, 32'h1);
    chk("t5_wr", {31'h0, dm_mem_write}, 32'h1);
    chk("t5_waddr", dm_addr, 32'h3FF);
    chk("t5_wf3", {29'h0, dm_funct3}, 32'h1);
    tick();
    chk("t5_served_stall", {31'h0, ld_stall}, 32'h0);
    chk("t5_lb_000", ld_data, 32'hFFFFFFAA);
    do_load(3'b100, 32'h3FF);
    chk("t5_lbu_3ff", ld_data, 32'h000000BB);
    no_load();

    // T6: invalid store funct3 is accepted and dropped
    do_store(3'b011, 32'h080, 32'h55555555);
    chk("t6_ready", {31'h0, st_ready}, 32'h1);
    tick();
    no_store();
    chk("t6_count", {29'h0, sb_count}, 32'h0);
    chk("t6_nowr", {31'h0, dm_mem_write}, 32'h0);

    // T7: reset with three buffered stores, mid-drain
    do_load(3'b010, 32'h300);
    do_store(3'b010, 32'h010, 32'h11110000); tick();
    do_store(3'b010, 32'h014, 32'h22220000); tick();
    do_store(3'b010, 32'h018, 32'h33330000); tick();
    no_store();
    chk("t7_count", {29'h0, sb_count}, 32'h3);
    no_load();
    chk("t7_draining", {31'h0, dm_mem_write}, 32'h1);
    rst = 1'b1;
    tick();
    chk("t7_rst_count", {29'h0, sb_count}, 32'h0);
    chk("t7_rst_nowr", {31'h0, dm_mem_write}, 32'h0);
    chk("t7_rst_ready", {31'h0, st_ready}, 32'h1);
    rst = 1'b0;
    tick();
    chk("t7_post_empty", {31'h0, sb_empty}, 32'h1);
    chk("t7_post_nowr", {31'h0, dm_mem_write}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_store_buffer.md
# dmem_store_buffer

Store buffer between the MEM-stage load/store issue logic and the 1 KB byte-addressable data memory (`dmem`). It accepts stores from the pipeline into a small FIFO and drains them one per cycle to the memory's synchronous write port. Loads go straight to the memory's combinational read port and take priority over draining. Any load that touches a buffered byte is stalled until it can be served correctly, either from memory or by forwarding (optional).

## Interface
- DEPTH, 4: store entries; power of two, ≥2.
- STARVE_LIMIT, 8: consecutive blocked-drain cycles before a drain is forced; ≥1.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- st_valid  in  1  store request.
- st_ready  out  1  buffer can accept; equals `count != DEPTH`.
- st_funct3  in  3  store width; 000=SB, 001=SH, 010=SW.
- st_addr  in  32  store byte address.
- st_data  in  32  store data; low bytes are significant.
- ld_valid  in  1  load request; combinational, same cycle.
- ld_funct3  in  3  load type; LB/LH/LW/LBU/LHU encodings.
- ld_addr  in  32  load byte address.
- ld_data  out  32  load result; sign- or zero-extended.
- ld_stall  out  1  load not served this cycle; pipeline holds the request.
- dm_mem_read, dm_mem_write  out  1 each  memory strobes.
- dm_funct3  out  3  memory access type.
- dm_addr  out  32  memory byte address.
- dm_write_data  out  32  memory write data.
- dm_read_data  in  32  memory read data.
- sb_empty  out  1  no entries buffered; drives fence completion.
- sb_count  out  $clog2(DEPTH)+1  occupancy.

## Operation
- Entry fields: addr[9:0], data[31:0], width[1:0]. Only addr[9:0] is significant because the memory aliases above 1 KB.
- Enqueue:
  - Occurs on `st_valid && st_ready` at the clock edge.
  - A store whose funct3 is not 000, 001 or 010 completes the handshake but is dropped. It is never enqueued.
- Footprint: an access covers bytes addr .. addr+size−1, mod 1024.
  - Overlap test is per byte on 10-bit addresses, wrap included.
  - Sub-module `sb_overlap_chk`: one instance per entry.
- Hazard: `ld_valid` is set and any valid entry overlaps the load footprint.
- No hazard:
  - `dm_mem_read=1`, dm_funct3/dm_addr take the load values.
  - `ld_data = dm_read_data`, `ld_stall=0`.
- Hazard, without forwarding: `ld_stall=1` and `dm_mem_read=0`.
- Drain:
  - `dm_mem_write=1` when the buffer is non-empty and either no unstalled load exists this cycle or the starvation force is active.
  - dm_funct3/dm_addr/dm_write_data take the head entry, with addr zero-extended to 32 bits.
  - The head is popped at the edge.
- Starvation:
  - `starve_cnt` increments each cycle the buffer is non-empty and no drain occurs.
  - It clears on any drain or when the buffer is empty.
  - When `starve_cnt == STARVE_LIMIT`, a drain is forced and a valid load sees `ld_stall=1` that cycle.
- Simultaneous push and pop: count is unchanged. A push while full is not accepted.
- Hazard loads never deadlock: a stalled load never blocks drain.
- Outputs default to 0 whenever the corresponding strobe is 0.

## Timing
- Reset values:
  - count=0, sb_empty=1, st_ready=1.
  - Head and tail pointers = 0, starve_cnt=0.
  - All dm_* outputs = 0, ld_data=0, ld_stall=0.
- Reset during operation discards all buffered stores. `dmem` clears at the same reset.
- Load latency is 0 cycles: fully combinational from ld_* and dm_read_data.
- Store latency:
  - Accepted at edge N; earliest memory write occurs at edge N+1.
  - A store accepted at edge N is not visible to hazard checks until cycle N+1.
  - The pipeline issues the store and a dependent load in different cycles.
- st_ready, sb_empty and sb_count are derived from registered state only. There is no combinational path from st_valid.

## Configuration
- `DMEM_SB_FWD_EN` defined: a hazard load is forwarded when all of the following hold:
  - the youngest overlapping entry has addr equal to ld_addr[9:0];
  - that entry's width is ≥ the load width;
  - the load is naturally contained in that entry.

  Then `ld_data` is built from the entry data and extended per ld_funct3, `ld_stall=0`, and `dm_mem_read=0`. The starvation force still overrides forwarding with a stall.
- Not defined: every hazard stalls. There is no forwarding mux or youngest-match priority logic.

## Structure
- Package `dmem_sb_pkg`:
  - funct3 constants: SB/SH/SW/LB/LH/LW/LBU/LHU.
  - width encoding and a function `width_bytes`.
  - the entry struct typedef.
  - the load-extend function, shared by the pass-through and forward paths.
- Sub-module `sb_overlap_chk`: takes two (addr[9:0], width) pairs and outputs a 1-bit overlap flag using 10-bit wrap arithmetic.

## Test plan
- Reset, then SW 0x100 ← 0xDEADBEEF; next cycle no load → dm_mem_write=1, dm_addr=0x100. Later LW 0x100 → ld_data=0xDEADBEEF, ld_stall=0.
- Fill 4 stores while ld_valid is held on a non-overlapping address every cycle → st_ready=0 at count=4. The 9th blocked cycle forces a drain with ld_stall=1; starve_cnt clears.
- SB 0x203 ← 0x80, then LH 0x202 the following cycle:
  - without the macro: ld_stall=1 until the entry drains, then ld_data=0xFFFF80xx (xx = the byte at 0x202 in memory);
  - with the macro: still stalls, because the store does not fully cover the load.
- With DMEM_SB_FWD_EN: SW 0x40 ← 0x1234_8765, SW 0x40 ← 0xCAFE_F00D, then LHU 0x40 → ld_data=0x0000F00D from the youngest entry, ld_stall=0, dm_mem_read=0.
- Wrap: SH 0x3FF ← 0xAABB, then LB 0x000 → hazard detected (byte 0x000 covered), stall, then ld_data=0xFFFFFFAA.
- st_funct3=3'b011 with st_valid → handshake completes, count unchanged. Assert rst mid-drain with 3 entries → next cycle count=0, dm_mem_write=0.
